// File: rtl/mesi_chk_pkg.sv
// Shared definitions for the MESI main-bus coherence checker.
//  - main-bus command encodings
//  - shadow_entry_t: one shadow-table line {valid, addr, data}. Fields are sized
//    to the widest supported bus; narrower buses are zero-extended on entry so
//    every stored bit stays meaningful in comparisons.
package mesi_chk_pkg;

  localparam int SHADOW_ADDR_W = 64;
  localparam int SHADOW_DATA_W = 64;

  localparam logic [2:0] MBUS_CMD_NOP      = 3'd0;
  localparam logic [2:0] MBUS_CMD_WR       = 3'd1;
  localparam logic [2:0] MBUS_CMD_RD       = 3'd2;
  localparam logic [2:0] MBUS_CMD_WR_BROAD = 3'd3;
  localparam logic [2:0] MBUS_CMD_RD_BROAD = 3'd4;

  typedef struct packed {
    logic                     valid;
    logic [SHADOW_ADDR_W-1:0] addr;
    logic [SHADOW_DATA_W-1:0] data;
  } shadow_entry_t;

endpackage

// File: rtl/mesi_chk_shadow_tbl.sv
// Fully-associative shadow table of recently written lines.
// Ports:
//  clk, rst       clock, synchronous active-high reset
//  addr           lookup / write address (combinational lookup)
//  wr_en          write this cycle: overwrite on hit, else allocate at replace ptr
//  wr_data        data to store
//  hit, rd_data   lookup result for addr (rd_data zero-extended, 0 on miss)
// Updates become visible on the cycle after wr_en.
module mesi_chk_shadow_tbl
  import mesi_chk_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TRACK_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_WIDTH-1:0]    addr,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     hit,
  output logic [SHADOW_DATA_W-1:0] rd_data
);

  localparam int PW = (TRACK_DEPTH > 1) ? $clog2(TRACK_DEPTH) : 1;

  shadow_entry_t           tbl [TRACK_DEPTH];
  logic [PW-1:0]           ptr;
  logic [PW-1:0]           hit_idx;
  logic [SHADOW_ADDR_W-1:0] key;

  assign key = SHADOW_ADDR_W'(addr);

  // Entries never hold duplicate addresses, so the first match is the only one.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    rd_data = '0;
    for (int i = TRACK_DEPTH - 1; i >= 0; i--) begin
      if (tbl[i].valid && tbl[i].addr == key) begin
        hit     = 1'b1;
        hit_idx = PW'(i);
        rd_data = tbl[i].data;
      end
    end
  end

  // TRACK_DEPTH is a power of two, so the pointer wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      for (int i = 0; i < TRACK_DEPTH; i++) tbl[i] <= '0;
    end else if (wr_en) begin
      if (hit) begin
        tbl[hit_idx].data <= SHADOW_DATA_W'(wr_data);
      end else begin
        tbl[ptr] <= '{valid: 1'b1, addr: key, data: SHADOW_DATA_W'(wr_data)};
        ptr      <= ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mesi_coher_checker.sv
// Coherence / protocol checker for the MESI ISC main bus.
// Watches every CPU's main-bus request and ack, keeps a shadow copy of
// recently written lines and raises sticky errors for:
//  err_data_o       read data differs from the shadow copy
//  err_stable_o[n]  CPU n changed cmd/addr before its ack
//  err_timeout_o[n] CPU n waited TIMEOUT cycles without ack
//  err_multi_ack_o  more than one ack bit in a cycle
// err_addr_o holds the address of the first data error; err_count_o counts
// every error event (saturating). chk_en_i=0 freezes the table, idles the
// per-CPU trackers and suppresses new errors. Inputs: clk, rst (sync, high),
// chk_en_i, packed per-CPU mbus_cmd_i/mbus_addr_i/mbus_data_wr_i, shared
// mbus_data_rd_i, per-CPU mbus_ack_i.
module mesi_coher_checker
  import mesi_chk_pkg::*;
#(
  parameter int CPU_COUNT      = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MBUS_CMD_WIDTH = 3,
  parameter int TRACK_DEPTH    = 8,
  parameter int TIMEOUT        = 64
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                chk_en_i,
  input  logic [CPU_COUNT*MBUS_CMD_WIDTH-1:0] mbus_cmd_i,
  input  logic [CPU_COUNT*ADDR_WIDTH-1:0]     mbus_addr_i,
  input  logic [CPU_COUNT*DATA_WIDTH-1:0]     mbus_data_wr_i,
  input  logic [DATA_WIDTH-1:0]               mbus_data_rd_i,
  input  logic [CPU_COUNT-1:0]                mbus_ack_i,
  output logic                                err_data_o,
  output logic [CPU_COUNT-1:0]                err_stable_o,
  output logic [CPU_COUNT-1:0]                err_timeout_o,
  output logic                                err_multi_ack_o,
  output logic [ADDR_WIDTH-1:0]               err_addr_o,
  output logic [15:0]                         err_count_o
);

  localparam int CW = MBUS_CMD_WIDTH;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] C_NOP = CW'(MBUS_CMD_NOP);
  localparam logic [CW-1:0] C_WR  = CW'(MBUS_CMD_WR);
  localparam logic [CW-1:0] C_RD  = CW'(MBUS_CMD_RD);
  localparam logic [CW-1:0] C_WRB = CW'(MBUS_CMD_WR_BROAD);
  localparam logic [CW-1:0] C_RDB = CW'(MBUS_CMD_RD_BROAD);

  logic [CPU_COUNT-1:0][CW-1:0]         cmd;
  logic [CPU_COUNT-1:0][ADDR_WIDTH-1:0] addr;
  logic [CPU_COUNT-1:0][DATA_WIDTH-1:0] wdata;

  assign cmd   = mbus_cmd_i;
  assign addr  = mbus_addr_i;
  assign wdata = mbus_data_wr_i;

  // ---- ack arbiter: lowest-index acked CPU owns the table this cycle ----
  logic                  sel_vld;
  logic [CW-1:0]         sel_cmd;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  always_comb begin
    sel_vld   = 1'b0;
    sel_cmd   = C_NOP;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int n = CPU_COUNT - 1; n >= 0; n--) begin
      if (mbus_ack_i[n]) begin
        sel_vld   = 1'b1;
        sel_cmd   = cmd[n];
        sel_addr  = addr[n];
        sel_wdata = wdata[n];
      end
    end
  end

  logic sel_wr, sel_rd;
  assign sel_wr = sel_vld && (sel_cmd == C_WR || sel_cmd == C_WRB);
  assign sel_rd = sel_vld && (sel_cmd == C_RD || sel_cmd == C_RDB);

  logic                     tbl_hit;
  logic [SHADOW_DATA_W-1:0] tbl_data;

  mesi_chk_shadow_tbl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .TRACK_DEPTH(TRACK_DEPTH)
  ) u_tbl (
    .clk    (clk),
    .rst    (rst),
    .addr   (sel_addr),
    .wr_en  (chk_en_i && sel_wr),
    .wr_data(sel_wdata),
    .hit    (tbl_hit),
    .rd_data(tbl_data)
  );

  // ---- per-CPU stability / timeout trackers ----
  logic [CPU_COUNT-1:0] stab_ev, to_ev;

  for (genvar n = 0; n < CPU_COUNT; n++) begin : g_cpu
    logic                  pend;
    logic [CW-1:0]         cap_cmd;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [TW-1:0]         cnt;
    logic                  active;

    assign active = cmd[n] != C_NOP;

    // An ack on the cycle of a change is treated as completing the request.
    assign stab_ev[n] = chk_en_i && pend && !mbus_ack_i[n] &&
                        (cmd[n] != cap_cmd || addr[n] != cap_addr);
    // Fires only on the step into TIMEOUT; the counter then parks there.
    assign to_ev[n]   = chk_en_i && active && !mbus_ack_i[n] &&
                        cnt == TW'(TIMEOUT - 1);

    always_ff @(posedge clk) begin
      if (rst || !chk_en_i) begin
        pend     <= 1'b0;
        cnt      <= '0;
        cap_cmd  <= C_NOP;
        cap_addr <= '0;
      end else begin
        if (!active || mbus_ack_i[n])  cnt <= '0;
        else if (cnt != TW'(TIMEOUT))  cnt <= cnt + 1'b1;

        if (!active || mbus_ack_i[n]) begin
          pend <= 1'b0;
        end else if (pend) begin
          if (stab_ev[n]) pend <= 1'b0;
        end else begin
          pend     <= 1'b1;
          cap_cmd  <= cmd[n];
          cap_addr <= addr[n];
        end
      end
    end
  end

  // ---- error events and sticky outputs ----
  logic        data_ev, multi_ev;
  logic [16:0] ev_num, cnt_sum;

  assign data_ev  = chk_en_i && sel_rd && tbl_hit &&
                    (tbl_data != SHADOW_DATA_W'(mbus_data_rd_i));
  assign multi_ev = chk_en_i && ($countones(mbus_ack_i) > 1);

  always_comb begin
    ev_num  = 17'(data_ev) + 17'(multi_ev) +
              17'($countones(stab_ev)) + 17'($countones(to_ev));
    cnt_sum = {1'b0, err_count_o} + ev_num;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_data_o      <= 1'b0;
      err_stable_o    <= '0;
      err_timeout_o   <= '0;
      err_multi_ack_o <= 1'b0;
      err_addr_o      <= '0;
      err_count_o     <= '0;
    end else begin
      err_data_o      <= err_data_o | data_ev;
      err_stable_o    <= err_stable_o | stab_ev;
      err_timeout_o   <= err_timeout_o | to_ev;
      err_multi_ack_o <= err_multi_ack_o | multi_ev;
      if (data_ev && !err_data_o) err_addr_o <= sel_addr;
      err_count_o     <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end

endmodule

// File: tb/tb_mesi_coher_checker.sv
module tb_mesi_coher_checker;

  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          chk_en_i;
  logic [NC*3-1:0]  mbus_cmd_i;
  logic [NC*32-1:0] mbus_addr_i;
  logic [NC*32-1:0] mbus_data_wr_i;
  logic [31:0]   mbus_data_rd_i;
  logic [NC-1:0] mbus_ack_i;
  logic          err_data_o;
  logic [NC-1:0] err_stable_o;
  logic [NC-1:0] err_timeout_o;
  logic          err_multi_ack_o;
  logic [31:0]   err_addr_o;
  logic [15:0]   err_count_o;

  mesi_coher_checker dut (
    .clk            (clk),
    .rst            (rst),
    .chk_en_i       (chk_en_i),
    .mbus_cmd_i     (mbus_cmd_i),
    .mbus_addr_i    (mbus_addr_i),
    .mbus_data_wr_i (mbus_data_wr_i),
    .mbus_data_rd_i (mbus_data_rd_i),
    .mbus_ack_i     (mbus_ack_i),
    .err_data_o     (err_data_o),
    .err_stable_o   (err_stable_o),
    .err_timeout_o  (err_timeout_o),
    .err_multi_ack_o(err_multi_ack_o),
    .err_addr_o     (err_addr_o),
    .err_count_o    (err_count_o)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] NOP = 3'd0, WR = 3'd1, RD = 3'd2, WRB = 3'd3, RDB = 3'd4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        dat;
    logic [3:0]  stab;
    logic [3:0]  to;
    logic        multi;
    logic [31:0] eaddr;
    logic [15:0] cnt;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  // Pops the oldest expectation and compares it with the registered outputs.
  task automatic score();
    exp_t e;
    if (sbq.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: empty queue");
      return;
    end
    e = sbq.pop_front();
    chk({e.name, ".err_data"},      32'(err_data_o),      32'(e.dat));
    chk({e.name, ".err_stable"},    32'(err_stable_o),    32'(e.stab));
    chk({e.name, ".err_timeout"},   32'(err_timeout_o),   32'(e.to));
    chk({e.name, ".err_multi_ack"}, 32'(err_multi_ack_o), 32'(e.multi));
    chk({e.name, ".err_addr"},      err_addr_o,           e.eaddr);
    chk({e.name, ".err_count"},     32'(err_count_o),     32'(e.cnt));
  endtask

  // One clock: queue the expectation for the stimulus now on the bus,
  // clock it in, then score outputs just after the edge.
  task automatic tick(input string nm, input logic dat, input logic [3:0] stab,
                      input logic [3:0] to, input logic multi,
                      input logic [31:0] eaddr, input logic [15:0] cnt);
    exp_t e;
    e.name = nm; e.dat = dat; e.stab = stab; e.to = to;
    e.multi = multi; e.eaddr = eaddr; e.cnt = cnt;
    sbq.push_back(e);
    @(posedge clk); #1;
    score();
  endtask

  task automatic clr_bus();
    mbus_cmd_i = '0; mbus_addr_i = '0; mbus_data_wr_i = '0;
    mbus_data_rd_i = '0; mbus_ack_i = '0;
  endtask

  task automatic set_cpu(input int cpu, input logic [2:0] c, input logic [31:0] a,
                         input logic [31:0] d);
    mbus_cmd_i[cpu*3 +: 3]      = c;
    mbus_addr_i[cpu*32 +: 32]   = a;
    mbus_data_wr_i[cpu*32 +: 32] = d;
  endtask

  task automatic do_reset();
    clr_bus(); rst = 1'b1; chk_en_i = 1'b1;
    tick("reset", 0, 4'h0, 4'h0, 0, 32'h0, 16'd0);
    rst = 1'b0;
  endtask

  // Single-CPU, single-cycle transactions with expected sticky state after each.
  typedef struct {
    logic        rst;
    int          cpu;
    logic [2:0]  cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic [3:0]  ack;
    logic        dat;
    logic [31:0] eaddr;
    logic [15:0] cnt;
  } vec_t;

  vec_t vt[9];

  initial begin
    vt[0] = '{1'b1, 0, NOP, 32'h0,   32'h0,         32'h0,         4'h0, 1'b0, 32'h0,   16'd0};
    vt[1] = '{1'b0, 0, WR,  32'h100, 32'hA5A5_0001, 32'h0,         4'h1, 1'b0, 32'h0,   16'd0};
    vt[2] = '{1'b0, 2, RD,  32'h100, 32'h0,         32'hA5A5_0001, 4'h4, 1'b0, 32'h0,   16'd0};
    vt[3] = '{1'b0, 2, RD,  32'h100, 32'h0,         32'hDEAD_BEEF, 4'h4, 1'b1, 32'h100, 16'd1};
    vt[4] = '{1'b0, 1, RDB, 32'h100, 32'h0,         32'hDEAD_BEEF, 4'h2, 1'b1, 32'h100, 16'd2};
    vt[5] = '{1'b0, 1, WRB, 32'h300, 32'h11,        32'h0,         4'h2, 1'b1, 32'h100, 16'd2};
    vt[6] = '{1'b0, 3, RD,  32'h300, 32'h0,         32'h12,        4'h8, 1'b1, 32'h100, 16'd3};
    vt[7] = '{1'b0, 0, RD,  32'h400, 32'h0,         32'h77,        4'h1, 1'b1, 32'h100, 16'd3};
    // reset while CPU0 has an unacked read outstanding
    vt[8] = '{1'b1, 0, RD,  32'h100, 32'h0,         32'h0,         4'h0, 1'b0, 32'h0,   16'd0};

    clr_bus(); rst = 1'b1; chk_en_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      clr_bus();
      rst = vt[i].rst;
      set_cpu(vt[i].cpu, vt[i].cmd, vt[i].addr, vt[i].wdata);
      mbus_data_rd_i = vt[i].rd;
      mbus_ack_i     = vt[i].ack;
      tick($sformatf("vec%0d", i), vt[i].dat, 4'h0, 4'h0, 1'b0, vt[i].eaddr, vt[i].cnt);
    end
    rst = 1'b0;

    // ---- eviction: 9 distinct writes into an 8-entry table ----
    for (int i = 0; i < 9; i++) begin
      clr_bus(); set_cpu(0, WR, 32'(i), 32'h1000 + 32'(i)); mbus_ack_i = 4'h1;
      tick($sformatf("fill%0d", i), 0, 4'h0, 4'h0, 0, 32'h0, 16'd0);
    end
    clr_bus(); set_cpu(1, RD, 32'h0, 0); mbus_data_rd_i = 32'hBAD; mbus_ack_i = 4'h2;
    tick("rd_evicted", 0, 4'h0, 4'h0, 0, 32'h0, 16'd0);
    clr_bus(); set_cpu(1, RD, 32'h8, 0); mbus_data_rd_i = 32'hBAD; mbus_ack_i = 4'h2;
    tick("rd_newest_bad", 1, 4'h0, 4'h0, 0, 32'h8, 16'd1);
    clr_bus(); set_cpu(2, RD, 32'h1, 0); mbus_data_rd_i = 32'h1001; mbus_ack_i = 4'h4;
    tick("rd_kept_good", 1, 4'h0, 4'h0, 0, 32'h8, 16'd1);
    clr_bus(); set_cpu(0, WR, 32'h8, 32'h2222); mbus_ack_i = 4'h1;
    tick("wr_hit", 1, 4'h0, 4'h0, 0, 32'h8, 16'd1);
    clr_bus(); set_cpu(2, RD, 32'h8, 0); mbus_data_rd_i = 32'h2222; mbus_ack_i = 4'h4;
    tick("rd_overwritten", 1, 4'h0, 4'h0, 0, 32'h8, 16'd1);
    clr_bus(); set_cpu(2, RD, 32'h1, 0); mbus_data_rd_i = 32'h0; mbus_ack_i = 4'h4;
    tick("rd_second_bad", 1, 4'h0, 4'h0, 0, 32'h8, 16'd2);
    chk_en_i = 1'b0;
    tick("chk_disabled", 1, 4'h0, 4'h0, 0, 32'h8, 16'd2);
    chk_en_i = 1'b1;

    // ---- timeout on CPU1 ----
    do_reset();
    for (int i = 0; i < 74; i++) begin
      clr_bus(); set_cpu(1, RD, 32'h40, 0);
      tick($sformatf("wait%0d", i), 0, 4'h0, (i >= 63) ? 4'b0010 : 4'b0000, 0, 32'h0,
           (i >= 63) ? 16'd1 : 16'd0);
    end
    mbus_ack_i = 4'h2;
    tick("late_ack", 0, 4'h0, 4'b0010, 0, 32'h0, 16'd1);
    clr_bus();
    tick("after_ack", 0, 4'h0, 4'b0010, 0, 32'h0, 16'd1);

    // ---- stability on CPU3 ----
    do_reset();
    clr_bus(); set_cpu(3, RD, 32'h200, 0);
    tick("stab_req", 0, 4'h0, 4'h0, 0, 32'h0, 16'd0);
    set_cpu(3, RD, 32'h204, 0);
    tick("stab_change", 0, 4'b1000, 4'h0, 0, 32'h0, 16'd1);
    mbus_ack_i = 4'h8;
    tick("stab_ack", 0, 4'b1000, 4'h0, 0, 32'h0, 16'd1);
    clr_bus();
    tick("stab_idle", 0, 4'b1000, 4'h0, 0, 32'h0, 16'd1);

    // ---- multi-ack: only CPU0's write reaches the table ----
    do_reset();
    clr_bus(); set_cpu(0, WR, 32'h500, 32'h55); set_cpu(2, WR, 32'h600, 32'h66);
    mbus_ack_i = 4'b0101;
    tick("multi_ack", 0, 4'h0, 4'h0, 1, 32'h0, 16'd1);
    clr_bus(); set_cpu(1, RD, 32'h600, 0); mbus_data_rd_i = 32'hBAD; mbus_ack_i = 4'h2;
    tick("multi_cpu2_dropped", 0, 4'h0, 4'h0, 1, 32'h0, 16'd1);
    clr_bus(); set_cpu(1, RD, 32'h500, 0); mbus_data_rd_i = 32'h99; mbus_ack_i = 4'h2;
    tick("multi_cpu0_kept", 1, 4'h0, 4'h0, 1, 32'h500, 16'd2);

    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
